moore_sequenciador: RTL and testbench

- Controller that generates the 4-bit state code ATUAL for the 10-state Moore sequence A..J (codes 0000..1001).
- Drives the existing output decoder, which maps ATUAL to S.
- Advances the state forward or backward on a manual step button or on an internal prescaler tick.
- Supports direct load of a state code, with illegal-code detection.

---
 rtl/moore_sequenciador.sv | 100 ++++++++++
 tb/tb_moore_sequenciador.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/moore_sequenciador.sv
// Ten-state Moore sequencer (A..J): steps on a synchronized button or a prescaler tick,
// in either direction, with direct load, wrap pulse and sticky illegal-load flag.
module moore_sequenciador #(
  parameter int unsigned DIV = 25000000,
  parameter int unsigned CW  = 25
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       modo,
  input  logic       passo,
  input  logic       dir,
  input  logic       pausa,
  input  logic       carrega,
  input  logic [3:0] valor,
  output logic [3:0] atual,
  output logic       volta,
  output logic       erro
);

  localparam logic [CW-1:0] CNT_MAX  = CW'(DIV - 1);
  localparam logic [3:0]    CODE_MAX = 4'd9;

  typedef enum logic [3:0] {
    A = 4'd0, B = 4'd1, C = 4'd2, D = 4'd3, E = 4'd4,
    F = 4'd5, G = 4'd6, H = 4'd7, I = 4'd8, J = 4'd9
  } estado_t;

  estado_t       estado;
  logic [CW-1:0] cnt;
  logic          sync1, sync2, hist;
  logic          step_m_c, tick_c, step_c, legal_c;

  assign atual = estado;

  // Edge detect on the synchronized button; only honoured in manual mode.
  assign step_m_c = sync2 & ~hist & ~modo;
  assign tick_c   = modo & ~pausa & (cnt == CNT_MAX);
  assign step_c   = (step_m_c | tick_c) & ~pausa;
  assign legal_c  = (valor <= CODE_MAX);

  // Button synchronizer and history; reset high so a held button is not a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      hist  <= 1'b1;
    end else begin
      sync1 <= passo;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  // Prescaler: cleared in manual mode, frozen while paused.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!modo) begin
      cnt <= '0;
    end else if (!pausa) begin
      cnt <= (cnt == CNT_MAX) ? '0 : cnt + CW'(1);
    end
  end

  // Sequence state with load taking priority over a step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado <= A;
      volta  <= 1'b0;
      erro   <= 1'b0;
    end else begin
      volta <= 1'b0;
      if (carrega) begin
        if (legal_c) begin
          estado <= estado_t'(valor);
          erro   <= 1'b0;
        end else begin
          erro   <= 1'b1;
        end
      end else if (step_c) begin
        if (!dir) begin
          if (estado == J) begin
            estado <= A;
            volta  <= 1'b1;
          end else begin
            estado <= estado_t'(estado + 4'd1);
          end
        end else begin
          if (estado == A) begin
            estado <= J;
            volta  <= 1'b1;
          end else begin
            estado <= estado_t'(estado - 4'd1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_moore_sequenciador.sv
// Directed bench for moore_sequenciador with a short prescaler period (DIV=4).
module tb_moore_sequenciador;

  localparam int unsigned DIV = 4;
  localparam int unsigned CW  = 3;

  logic       clk, rst_n, modo, passo, dir, pausa, carrega;
  logic [3:0] valor;
  logic [3:0] atual;
  logic       volta, erro;

  int checks = 0;
  int errors = 0;

  moore_sequenciador #(.DIV(DIV), .CW(CW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .modo    (modo),
    .passo   (passo),
    .dir     (dir),
    .pausa   (pausa),
    .carrega (carrega),
    .valor   (valor),
    .atual   (atual),
    .volta   (volta),
    .erro    (erro)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got t=%0t required finish earlier", $time);
    $fatal(1, "timeout");
  end

  // One button press; the new code must appear on the third edge after passo rises.
  task automatic press(input int hold, input logic [3:0] prev, input logic [3:0] exp_a,
                       input logic exp_v);
    passo = 1'b1;
    for (int e = 0; e < 2; e++) begin
      @(negedge clk);
      checks++;
      if (atual !== prev) begin
        errors++;
        $display("FAIL press_early edge%0d: atual got %b required %b", e, atual, prev);
      end
    end
    @(negedge clk);
    checks++;
    if (atual !== exp_a) begin
      errors++;
      $display("FAIL press_step: atual got %b required %b", atual, exp_a);
    end
    checks++;
    if (volta !== exp_v) begin
      errors++;
      $display("FAIL press_volta: volta got %b required %b", volta, exp_v);
    end
    @(negedge clk);
    checks++;
    if (volta !== 1'b0) begin
      errors++;
      $display("FAIL press_volta_pulse: volta got %b required 0", volta);
    end
    repeat (hold) @(negedge clk);
    passo = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (atual !== exp_a) begin
      errors++;
      $display("FAIL press_single: atual got %b required %b", atual, exp_a);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; modo = 1'b0; passo = 1'b1; dir = 1'b0; pausa = 1'b0;
    carrega = 1'b0; valor = 4'd0;
    @(negedge clk);
    checks++;
    if ({atual, volta, erro} !== 6'b0) begin
      errors++;
      $display("FAIL reset_state: atual/volta/erro got %b/%b/%b required 0000/0/0",
               atual, volta, erro);
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (atual !== 4'd0) begin
      errors++;
      $display("FAIL reset_held_button: atual got %b required 0000", atual);
    end
    passo = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_manual();
    dir = 1'b0; modo = 1'b0;
    press(0, 4'd0, 4'd1, 1'b0);
    press(0, 4'd1, 4'd2, 1'b0);
    press(6, 4'd2, 4'd3, 1'b0);
  endtask

  task automatic test_auto();
    logic [3:0] exp_a;
    logic       exp_v;
    int         exp_cnt;
    carrega = 1'b1; valor = 4'd0;
    @(negedge clk);
    carrega = 1'b0;
    checks++;
    if (atual !== 4'd0) begin
      errors++;
      $display("FAIL auto_preload: atual got %b required 0000", atual);
    end
    exp_a = 4'd0; exp_cnt = 0;
    modo = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      exp_v = 1'b0;
      if (exp_cnt == DIV - 1) begin
        exp_cnt = 0;
        if (exp_a == 4'd9) begin
          exp_a = 4'd0;
          exp_v = 1'b1;
        end else begin
          exp_a = exp_a + 4'd1;
        end
      end else begin
        exp_cnt++;
      end
      checks++;
      if (atual !== exp_a || volta !== exp_v) begin
        errors++;
        $display("FAIL auto_cycle%0d: atual/volta got %b/%b required %b/%b",
                 c, atual, volta, exp_a, exp_v);
      end
    end
    modo = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reverse();
    dir = 1'b1;
    press(0, 4'd0, 4'd9, 1'b1);
    press(0, 4'd9, 4'd8, 1'b0);
  endtask

  task automatic test_load_tick();
    dir = 1'b0; modo = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (atual !== 4'd8) begin
      errors++;
      $display("FAIL load_pre_tick: atual got %b required 1000", atual);
    end
    carrega = 1'b1; valor = 4'd7;
    @(negedge clk);
    checks++;
    if (atual !== 4'd7 || volta !== 1'b0 || erro !== 1'b0) begin
      errors++;
      $display("FAIL load_over_tick: atual/volta/erro got %b/%b/%b required 0111/0/0",
               atual, volta, erro);
    end
    checks++;
    if (dut.cnt !== 3'd0) begin
      errors++;
      $display("FAIL load_cnt_wrap: cnt got %0d required 0", dut.cnt);
    end
    valor = 4'd12;
    @(negedge clk);
    checks++;
    if (atual !== 4'd7 || erro !== 1'b1) begin
      errors++;
      $display("FAIL load_illegal: atual/erro got %b/%b required 0111/1", atual, erro);
    end
    valor = 4'd2;
    @(negedge clk);
    checks++;
    if (atual !== 4'd2 || erro !== 1'b0) begin
      errors++;
      $display("FAIL load_legal_clear: atual/erro got %b/%b required 0010/0", atual, erro);
    end
    carrega = 1'b0; modo = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_pause();
    pausa = 1'b1; modo = 1'b0;
    press(0, 4'd2, 4'd2, 1'b0);
    pausa = 1'b0; modo = 1'b1;
    repeat (2) @(negedge clk);
    pausa = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (atual !== 4'd2 || dut.cnt !== 3'd2) begin
      errors++;
      $display("FAIL pause_freeze: atual/cnt got %b/%0d required 0010/2", atual, dut.cnt);
    end
    pausa = 1'b0;
    @(negedge clk);
    checks++;
    if (atual !== 4'd2) begin
      errors++;
      $display("FAIL pause_resume_early: atual got %b required 0010", atual);
    end
    @(negedge clk);
    checks++;
    if (atual !== 4'd3 || dut.cnt !== 3'd0) begin
      errors++;
      $display("FAIL pause_resume_tick: atual/cnt got %b/%0d required 0011/0", atual, dut.cnt);
    end
  endtask

  task automatic test_reset_mid();
    carrega = 1'b1; valor = 4'd15;
    @(negedge clk);
    carrega = 1'b0;
    checks++;
    if (erro !== 1'b1) begin
      errors++;
      $display("FAIL mid_erro_set: erro got %b required 1", erro);
    end
    @(negedge clk);
    passo = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (atual !== 4'd0 || dut.cnt !== 3'd0 || erro !== 1'b0 || volta !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: atual/cnt/erro/volta got %b/%0d/%b/%b required 0000/0/0/0",
               atual, dut.cnt, erro, volta);
    end
    @(negedge clk);
    rst_n = 1'b1; modo = 1'b0; dir = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (atual !== 4'd0) begin
      errors++;
      $display("FAIL mid_press_no_step: atual got %b required 0000", atual);
    end
    passo = 1'b0;
    repeat (3) @(negedge clk);
    press(0, 4'd0, 4'd1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_manual();
    test_auto();
    test_reverse();
    test_load_tick();
    test_pause();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
